// File: rtl/me_pkg.sv
// Shared types and width helpers for the full-search block-matching motion estimator.
package me_pkg;

  typedef enum logic [1:0] {StIdle, StAcc, StCandEnd, StFin} state_e;

  localparam int unsigned PixWDefault = 8;
  typedef logic [PixWDefault-1:0] pixel_t;

  // Width that holds the worst-case SAD of a blk x blk block.
  function automatic int unsigned sad_w(input int unsigned blk, input int unsigned pix_w);
    return $clog2(blk * blk * ((1 << pix_w) - 1) + 1);
  endfunction

  // Word-address width of a square image of edge_len pixels, eight pixels per word.
  function automatic int unsigned addr_w(input int unsigned edge_len);
    return $clog2(edge_len * edge_len / 8);
  endfunction

endpackage

// File: rtl/me_search_engine_if.sv
// Memory-load, control and result signals of the motion-estimation search engine.
interface me_search_engine_if #(
  parameter int unsigned BLK   = 16,
  parameter int unsigned WIN   = 32,
  parameter int unsigned PIX_W = 8
) ();
  import me_pkg::*;

  localparam int unsigned SAD_W  = sad_w(BLK, PIX_W);
  localparam int unsigned CUR_AW = addr_w(BLK);
  localparam int unsigned REF_AW = addr_w(WIN);

  logic [CUR_AW-1:0]  address_write_cur;
  logic [8*PIX_W-1:0] data_write_cur;
  logic               write_enable_cur;
  logic [REF_AW-1:0]  address_write_ref;
  logic [8*PIX_W-1:0] data_write_ref;
  logic               write_enable_ref;
  logic               go;
  logic               early_term;
  logic [SAD_W-1:0]   sad_thresh;
  logic               busy;
  logic               done;
  logic [7:0]         m_i;
  logic [7:0]         m_j;
  logic [SAD_W-1:0]   min_sad;

  modport master (
    output address_write_cur, data_write_cur, write_enable_cur,
    output address_write_ref, data_write_ref, write_enable_ref,
    output go, early_term, sad_thresh,
    input  busy, done, m_i, m_j, min_sad
  );

  modport slave (
    input  address_write_cur, data_write_cur, write_enable_cur,
    input  address_write_ref, data_write_ref, write_enable_ref,
    input  go, early_term, sad_thresh,
    output busy, done, m_i, m_j, min_sad
  );

endinterface

// File: rtl/me_sad_row.sv
// Combinational sum of absolute differences across one block row.
module me_sad_row #(
  parameter int unsigned BLK   = 16,
  parameter int unsigned PIX_W = 8,
  parameter int unsigned OUT_W = 16
) (
  input  logic [BLK*PIX_W-1:0] cur_i,
  input  logic [BLK*PIX_W-1:0] ref_i,
  output logic [OUT_W-1:0]     sad_o
);

  always_comb begin
    sad_o = '0;
    for (int k = 0; k < BLK; k++) begin
      sad_o = sad_o + OUT_W'((cur_i[k*PIX_W +: PIX_W] > ref_i[k*PIX_W +: PIX_W]) ?
                             (cur_i[k*PIX_W +: PIX_W] - ref_i[k*PIX_W +: PIX_W]) :
                             (ref_i[k*PIX_W +: PIX_W] - cur_i[k*PIX_W +: PIX_W]));
    end
  end

endmodule

// File: rtl/me_search_engine.sv
// Full-search block matcher: one block row per cycle, raster candidate order,
// optional abandon/early-stop on the running best SAD.
module me_search_engine
  import me_pkg::*;
#(
  parameter int unsigned BLK   = 16,
  parameter int unsigned WIN   = 32,
  parameter int unsigned PIX_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  me_search_engine_if.slave bus
);

  localparam int unsigned SAD_W  = sad_w(BLK, PIX_W);
  localparam int unsigned CUR_IW = $clog2(BLK * BLK);
  localparam int unsigned REF_IW = $clog2(WIN * WIN);
  localparam logic [7:0]  MaxOff  = 8'(WIN - BLK);
  localparam logic [7:0]  LastRow = 8'(BLK - 1);

  logic [PIX_W-1:0] cur_mem [BLK*BLK];
  logic [PIX_W-1:0] ref_mem [WIN*WIN];

  state_e           state_q, state_d;
  logic [7:0]       cand_i_q, cand_i_d, cand_j_q, cand_j_d, row_q, row_d;
  logic [SAD_W-1:0] acc_q, acc_d, best_q, best_d, thresh_q, thresh_d;
  logic [7:0]       best_i_q, best_i_d, best_j_q, best_j_d;
  logic             abandon_q, abandon_d, early_q, early_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [7:0]       m_i_q, m_i_d, m_j_q, m_j_d;
  logic [SAD_W-1:0] min_sad_q, min_sad_d;

  logic [BLK*PIX_W-1:0] cur_row, ref_row;
  logic [SAD_W-1:0]     row_sad, acc_sum, best_nx;
  logic [7:0]           best_i_nx, best_j_nx;
  logic                 cand_upd, last_cand;

  // Word address maps to the linear pixel index address*8, since rows are whole words.
  always_ff @(posedge clk) begin
    if (bus.write_enable_cur && !busy_q) begin
      for (int p = 0; p < 8; p++) begin
        cur_mem[CUR_IW'(int'(bus.address_write_cur) * 8 + p)] <=
          bus.data_write_cur[p*PIX_W +: PIX_W];
      end
    end
    if (bus.write_enable_ref && !busy_q) begin
      for (int p = 0; p < 8; p++) begin
        ref_mem[REF_IW'(int'(bus.address_write_ref) * 8 + p)] <=
          bus.data_write_ref[p*PIX_W +: PIX_W];
      end
    end
  end

  always_comb begin
    cur_row = '0;
    ref_row = '0;
    for (int k = 0; k < BLK; k++) begin
      cur_row[k*PIX_W +: PIX_W] = cur_mem[CUR_IW'(int'(row_q) * BLK + k)];
      ref_row[k*PIX_W +: PIX_W] =
        ref_mem[REF_IW'((int'(cand_i_q) + int'(row_q)) * WIN + int'(cand_j_q) + k)];
    end
  end

  me_sad_row #(
    .BLK  (BLK),
    .PIX_W(PIX_W),
    .OUT_W(SAD_W)
  ) u_sad_row (
    .cur_i(cur_row),
    .ref_i(ref_row),
    .sad_o(row_sad)
  );

  assign acc_sum   = acc_q + row_sad;
  assign cand_upd  = !abandon_q && (acc_q < best_q);
  assign best_nx   = cand_upd ? acc_q : best_q;
  assign best_i_nx = cand_upd ? cand_i_q : best_i_q;
  assign best_j_nx = cand_upd ? cand_j_q : best_j_q;
  assign last_cand = (cand_i_q == MaxOff) && (cand_j_q == MaxOff);

  always_comb begin
    state_d   = state_q;
    cand_i_d  = cand_i_q;
    cand_j_d  = cand_j_q;
    row_d     = row_q;
    acc_d     = acc_q;
    best_d    = best_q;
    best_i_d  = best_i_q;
    best_j_d  = best_j_q;
    abandon_d = abandon_q;
    early_d   = early_q;
    thresh_d  = thresh_q;
    busy_d    = busy_q;
    done_d    = done_q;
    m_i_d     = m_i_q;
    m_j_d     = m_j_q;
    min_sad_d = min_sad_q;
    unique case (state_q)
      StIdle: begin
        if (bus.go) begin
          state_d   = StAcc;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          best_d    = '1;
          cand_i_d  = '0;
          cand_j_d  = '0;
          row_d     = '0;
          acc_d     = '0;
          abandon_d = 1'b0;
          early_d   = bus.early_term;
          thresh_d  = bus.sad_thresh;
        end
      end
      StAcc: begin
        acc_d = acc_sum;
        if (early_q && (acc_sum >= best_q)) begin
          abandon_d = 1'b1;
          state_d   = StCandEnd;
        end else if (row_q == LastRow) begin
          state_d = StCandEnd;
        end else begin
          row_d = row_q + 8'd1;
        end
      end
      StCandEnd: begin
        best_d   = best_nx;
        best_i_d = best_i_nx;
        best_j_d = best_j_nx;
        if (last_cand || (early_q && (best_nx <= thresh_q))) begin
          state_d   = StFin;
          m_i_d     = best_i_nx;
          m_j_d     = best_j_nx;
          min_sad_d = best_nx;
        end else begin
          state_d   = StAcc;
          row_d     = '0;
          acc_d     = '0;
          abandon_d = 1'b0;
          if (cand_j_q == MaxOff) begin
            cand_j_d = '0;
            cand_i_d = cand_i_q + 8'd1;
          end else begin
            cand_j_d = cand_j_q + 8'd1;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cand_i_q  <= '0;
      cand_j_q  <= '0;
      row_q     <= '0;
      acc_q     <= '0;
      best_q    <= '0;
      best_i_q  <= '0;
      best_j_q  <= '0;
      abandon_q <= 1'b0;
      early_q   <= 1'b0;
      thresh_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      m_i_q     <= '0;
      m_j_q     <= '0;
      min_sad_q <= '0;
    end else begin
      state_q   <= state_d;
      cand_i_q  <= cand_i_d;
      cand_j_q  <= cand_j_d;
      row_q     <= row_d;
      acc_q     <= acc_d;
      best_q    <= best_d;
      best_i_q  <= best_i_d;
      best_j_q  <= best_j_d;
      abandon_q <= abandon_d;
      early_q   <= early_d;
      thresh_q  <= thresh_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      m_i_q     <= m_i_d;
      m_j_q     <= m_j_d;
      min_sad_q <= min_sad_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.m_i     = m_i_q;
  assign bus.m_j     = m_j_q;
  assign bus.min_sad = min_sad_q;

endmodule

// File: tb/tb_me_search_engine.sv
// Directed bench for me_search_engine: known-answer searches, disturbance and mid-search reset.
module tb_me_search_engine;
  import me_pkg::*;

  localparam int unsigned BLK    = 16;
  localparam int unsigned WIN    = 32;
  localparam int unsigned PIX_W  = 8;
  localparam int unsigned SAD_W  = sad_w(BLK, PIX_W);
  localparam int unsigned CUR_AW = addr_w(BLK);
  localparam int unsigned REF_AW = addr_w(WIN);
  localparam int          FULL_LAT = 289 * 17 + 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  me_search_engine_if #(.BLK(BLK), .WIN(WIN), .PIX_W(PIX_W)) bus ();

  me_search_engine #(.BLK(BLK), .WIN(WIN), .PIX_W(PIX_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  int lat;
  pixel_t cur_img [BLK][BLK];
  pixel_t ref_img [WIN][WIN];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1 lat++;
  endtask

  task automatic write_cur(input int a, input logic [63:0] d);
    bus.address_write_cur = CUR_AW'(a);
    bus.data_write_cur    = d;
    bus.write_enable_cur  = 1'b1;
    @(posedge clk);
    #1 bus.write_enable_cur = 1'b0;
  endtask

  task automatic write_ref(input int a, input logic [63:0] d);
    bus.address_write_ref = REF_AW'(a);
    bus.data_write_ref    = d;
    bus.write_enable_ref  = 1'b1;
    @(posedge clk);
    #1 bus.write_enable_ref = 1'b0;
  endtask

  task automatic load_images();
    logic [63:0] w;
    for (int a = 0; a < BLK * BLK / 8; a++) begin
      for (int p = 0; p < 8; p++) w[p*8 +: 8] = cur_img[a / (BLK/8)][(a % (BLK/8)) * 8 + p];
      write_cur(a, w);
    end
    for (int a = 0; a < WIN * WIN / 8; a++) begin
      for (int p = 0; p < 8; p++) w[p*8 +: 8] = ref_img[a / (WIN/8)][(a % (WIN/8)) * 8 + p];
      write_ref(a, w);
    end
  endtask

  task automatic start_go(input logic early, input logic [SAD_W-1:0] thresh);
    bus.early_term = early;
    bus.sad_thresh = thresh;
    bus.go         = 1'b1;
    lat            = 0;
    step();
    bus.go = 1'b0;
    chk("go_clears_done", 32'(bus.done), 32'd0);
    chk("go_sets_busy", 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_done();
    while (bus.done !== 1'b1 && lat < 20000) step();
    chk("done_reached", 32'(bus.done), 32'd1);
  endtask

  function automatic logic [31:0] sad_at(input int i, input int j);
    logic [31:0] s = 0;
    for (int r = 0; r < BLK; r++)
      for (int c = 0; c < BLK; c++) begin
        int a = int'(cur_img[r][c]);
        int b = int'(ref_img[i + r][j + c]);
        s += 32'((a > b) ? a - b : b - a);
      end
    return s;
  endfunction

  task automatic model_best(output int bi, output int bj, output logic [31:0] bs);
    logic [31:0] s;
    bs = '1; bi = 0; bj = 0;
    for (int i = 0; i <= int'(WIN - BLK); i++)
      for (int j = 0; j <= int'(WIN - BLK); j++) begin
        s = sad_at(i, j);
        if (s < bs) begin bs = s; bi = i; bj = j; end
      end
  endtask

  task automatic fill_pattern();
    for (int r = 0; r < WIN; r++) for (int c = 0; c < WIN; c++) ref_img[r][c] = 8'h00;
    for (int r = 0; r < BLK; r++)
      for (int c = 0; c < BLK; c++) begin
        cur_img[r][c] = pixel_t'((r * 16 + c) % 250 + 1);
        ref_img[5 + r][9 + c] = cur_img[r][c];
      end
  endtask

  initial begin
    int mi, mj;
    logic [31:0] ms, sad00;
    bus.address_write_cur = '0; bus.data_write_cur = '0; bus.write_enable_cur = 1'b0;
    bus.address_write_ref = '0; bus.data_write_ref = '0; bus.write_enable_ref = 1'b0;
    bus.go = 1'b0; bus.early_term = 1'b0; bus.sad_thresh = '0;

    #2 reset = 1'b1;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_m_i", 32'(bus.m_i), 32'd0);
    chk("rst_m_j", 32'(bus.m_j), 32'd0);
    chk("rst_min_sad", 32'(bus.min_sad), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // Flat images: every candidate ties at zero, the first one wins.
    for (int r = 0; r < WIN; r++) for (int c = 0; c < WIN; c++) ref_img[r][c] = 8'h10;
    for (int r = 0; r < BLK; r++) for (int c = 0; c < BLK; c++) cur_img[r][c] = 8'h10;
    load_images();
    start_go(1'b0, '0);
    wait_done();
    chk("flat_latency", 32'(lat), 32'(FULL_LAT));
    chk("flat_m_i", 32'(bus.m_i), 32'd0);
    chk("flat_m_j", 32'(bus.m_j), 32'd0);
    chk("flat_min_sad", 32'(bus.min_sad), 32'd0);
    chk("flat_busy_after", 32'(bus.busy), 32'd0);
    step();
    chk("done_held", 32'(bus.done), 32'd1);

    fill_pattern();
    load_images();
    start_go(1'b0, '0);
    wait_done();
    chk("pat_latency", 32'(lat), 32'(FULL_LAT));
    chk("pat_m_i", 32'(bus.m_i), 32'd5);
    chk("pat_m_j", 32'(bus.m_j), 32'd9);
    chk("pat_min_sad", 32'(bus.min_sad), 32'd0);

    // Early stop at the exact match: candidate 94 is the 95th visited.
    start_go(1'b1, '0);
    wait_done();
    chk("early_faster", 32'(lat < FULL_LAT), 32'd1);
    chk("early_bound", 32'(lat <= 95 * 17 + 2), 32'd1);
    chk("early_m_i", 32'(bus.m_i), 32'd5);
    chk("early_m_j", 32'(bus.m_j), 32'd9);
    chk("early_min_sad", 32'(bus.min_sad), 32'd0);

    // Threshold at maximum stops after the very first candidate.
    sad00 = sad_at(0, 0);
    start_go(1'b1, '1);
    wait_done();
    chk("thr_latency", 32'(lat), 32'd19);
    chk("thr_m_i", 32'(bus.m_i), 32'd0);
    chk("thr_m_j", 32'(bus.m_j), 32'd0);
    chk("thr_min_sad", 32'(bus.min_sad), sad00);

    // Disturbance: go and memory writes during busy must be ignored.
    start_go(1'b0, '0);
    repeat (30) step();
    bus.go = 1'b1;
    step();
    bus.go = 1'b0;
    bus.address_write_ref = REF_AW'(5 * 4 + 1);
    bus.data_write_ref    = '1;
    bus.write_enable_ref  = 1'b1;
    bus.address_write_cur = CUR_AW'(0);
    bus.data_write_cur    = '1;
    bus.write_enable_cur  = 1'b1;
    step();
    bus.write_enable_ref = 1'b0;
    bus.write_enable_cur = 1'b0;
    chk("dist_busy", 32'(bus.busy), 32'd1);
    chk("dist_hold_min_sad", 32'(bus.min_sad), sad00);
    wait_done();
    chk("dist_latency", 32'(lat), 32'(FULL_LAT));
    chk("dist_m_i", 32'(bus.m_i), 32'd5);
    chk("dist_m_j", 32'(bus.m_j), 32'd9);
    chk("dist_min_sad", 32'(bus.min_sad), 32'd0);

    // Reset 100 cycles into a search, then a fresh search against the model.
    start_go(1'b0, '0);
    repeat (49) step();
    chk("mid_hold_m_j", 32'(bus.m_j), 32'd9);
    repeat (50) step();
    reset = 1'b1;
    #1;
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_done", 32'(bus.done), 32'd0);
    chk("mrst_m_i", 32'(bus.m_i), 32'd0);
    chk("mrst_m_j", 32'(bus.m_j), 32'd0);
    chk("mrst_min_sad", 32'(bus.min_sad), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    step();
    chk("post_rst_done", 32'(bus.done), 32'd0);

    for (int r = 0; r < BLK; r++)
      for (int c = 0; c < BLK; c++) cur_img[r][c] = pixel_t'((r * 29 + c * 13 + 5) % 256);
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN; c++)
        ref_img[r][c] = pixel_t'((r * r * 7 + c * 31 + r * c * 3 + 11) % 256);
    load_images();
    model_best(mi, mj, ms);
    start_go(1'b0, '0);
    wait_done();
    chk("model_latency", 32'(lat), 32'(FULL_LAT));
    chk("model_m_i", 32'(bus.m_i), 32'(mi));
    chk("model_m_j", 32'(bus.m_j), 32'(mj));
    chk("model_min_sad", 32'(bus.min_sad), ms);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
